// File: rtl/tlb_pkg.sv
// ---------------------------------------------------------------------------
// tlb_pkg
// Shared definitions for the TLB maintenance engine: maintenance op codes,
// the packed TLB entry layout, INVTLB op encodings, the FSM state type and
// the 16-bit victim-selection LFSR.
//
// Entry layout, MSB first (89 bits):
//   {E, VPPN[18:0], PS[5:0], ASID[9:0], G,
//    PPN0[19:0], PLV0[1:0], MAT0[1:0], D0, V0,
//    PPN1[19:0], PLV1[1:0], MAT1[1:0], D1, V1}
// ---------------------------------------------------------------------------
package tlb_pkg;

  localparam int ENTRY_W = 89;

  // Field offsets (LSB position) inside the packed entry
  localparam int E_BIT    = 88;
  localparam int VPPN_LSB = 69;
  localparam int VPPN_W   = 19;
  localparam int PS_LSB   = 63;
  localparam int PS_W     = 6;
  localparam int ASID_LSB = 53;
  localparam int ASID_W   = 10;
  localparam int G_BIT    = 52;
  localparam int PPN0_LSB = 32;
  localparam int PLV0_LSB = 30;
  localparam int MAT0_LSB = 28;
  localparam int D0_BIT   = 27;
  localparam int V0_BIT   = 26;
  localparam int PPN1_LSB = 6;
  localparam int PLV1_LSB = 4;
  localparam int MAT1_LSB = 2;
  localparam int D1_BIT   = 1;
  localparam int V1_BIT   = 0;

  // Maintenance op codes on req_op; anything else completes as a no-op
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;

  // INVTLB op encodings
  localparam logic [4:0] INV_ALL0       = 5'd0;
  localparam logic [4:0] INV_ALL1       = 5'd1;
  localparam logic [4:0] INV_G1         = 5'd2;
  localparam logic [4:0] INV_G0         = 5'd3;
  localparam logic [4:0] INV_G0_ASID    = 5'd4;
  localparam logic [4:0] INV_G0_ASID_VA = 5'd5;
  localparam logic [4:0] INV_GA_VA      = 5'd6;
  localparam logic [4:0] INV_OP_MAX     = INV_GA_VA;

  // Page size that selects the coarse (vppn[18:9]) address compare
  localparam logic [5:0] PS_HUGE = 6'd21;

  // Fibonacci LFSR, x^16+x^14+x^13+x^11+1, right-shifting form:
  // feedback taps sit at bit positions 0, 2, 3 and 5.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/tlb_maint_unit_inv_match.sv
// ---------------------------------------------------------------------------
// tlb_inv_match
// Combinational match of one TLB entry against an INVTLB selector. The E bit
// is deliberately not considered here so the same block can serve lookups
// that qualify validity themselves.
//
// Ports:
//   entry_i   packed TLB entry
//   inv_op_i  INVTLB op (0..6 meaningful; others never match)
//   asid_i    ASID operand
//   vppn_i    VPPN operand
//   match_o   entry selected by the op
// ---------------------------------------------------------------------------
module tlb_inv_match
  import tlb_pkg::*;
(
  input  logic [ENTRY_W-1:0] entry_i,
  input  logic [4:0]         inv_op_i,
  input  logic [9:0]         asid_i,
  input  logic [18:0]        vppn_i,
  output logic               match_o
);

  logic              g;
  logic              asid_eq;
  logic              vppn_eq;
  logic [VPPN_W-1:0] e_vppn;

  assign g       = entry_i[G_BIT];
  assign e_vppn  = entry_i[VPPN_LSB +: VPPN_W];
  assign asid_eq = (entry_i[ASID_LSB +: ASID_W] == asid_i);

  // 4 MB pages only translate on the upper ten VPPN bits
  assign vppn_eq = (entry_i[PS_LSB +: PS_W] == PS_HUGE) ?
                   (e_vppn[18:9] == vppn_i[18:9]) :
                   (e_vppn == vppn_i);

  always_comb begin
    match_o = 1'b0;
    case (inv_op_i)
      INV_ALL0, INV_ALL1: match_o = 1'b1;
      INV_G1:             match_o = g;
      INV_G0:             match_o = ~g;
      INV_G0_ASID:        match_o = ~g & asid_eq;
      INV_G0_ASID_VA:     match_o = ~g & asid_eq & vppn_eq;
      INV_GA_VA:          match_o = (g | asid_eq) & vppn_eq;
      default:            match_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/tlb_maint_unit.sv
// ---------------------------------------------------------------------------
// tlb_maint_unit
// TLB maintenance engine beside writeback. Executes TLBRD, TLBWR, TLBFILL and
// INVTLB through one TLB read port and one write port. INVTLB walks the whole
// array one entry per cycle, so the array size is not limited by a
// single-cycle invalidate.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid / req_ready      op handshake from WB (ready only when idle)
//   req_op                     1=RD 2=WR 3=FILL 4=INV, others no-op
//   req_inv_op/asid/vppn       INVTLB operands
//   csr_idx, csr_ne,
//   csr_refill, csr_entry      CSR-side index and entry image
//   r_index / r_entry          TLB read port (combinational data)
//   w_we / w_index / w_entry   TLB write port
//   done_valid, done_err       completion pulse; err flags illegal INV op
//   rd_entry, rd_hit           last TLBRD result and its E bit
// ---------------------------------------------------------------------------
module tlb_maint_unit
  import tlb_pkg::*;
#(
  parameter  int TLBNUM    = 16,
  parameter  int FILL_MODE = 0,
  localparam int IDX_W     = $clog2(TLBNUM)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_op,
  input  logic [4:0]         req_inv_op,
  input  logic [9:0]         req_inv_asid,
  input  logic [18:0]        req_inv_vppn,
  input  logic [IDX_W-1:0]   csr_idx,
  input  logic               csr_ne,
  input  logic               csr_refill,
  input  logic [ENTRY_W-1:0] csr_entry,
  output logic [IDX_W-1:0]   r_index,
  input  logic [ENTRY_W-1:0] r_entry,
  output logic               w_we,
  output logic [IDX_W-1:0]   w_index,
  output logic [ENTRY_W-1:0] w_entry,
  output logic               done_valid,
  output logic               done_err,
  output logic [ENTRY_W-1:0] rd_entry,
  output logic               rd_hit
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLBNUM - 1);

  state_e             state_q,    state_d;
  logic               done_err_q, done_err_d;
  logic [ENTRY_W-1:0] rd_entry_q, rd_entry_d;
  logic [IDX_W-1:0]   fill_ptr_q, fill_ptr_d;
  logic [15:0]        lfsr_q,     lfsr_d;
  logic [IDX_W-1:0]   scan_ptr_q, scan_ptr_d;
  logic [4:0]         inv_op_q,   inv_op_d;
  logic [9:0]         inv_asid_q, inv_asid_d;
  logic [18:0]        inv_vppn_q, inv_vppn_d;

  logic [IDX_W-1:0]   victim;
  logic [ENTRY_W-1:0] wr_image;
  logic [ENTRY_W-1:0] inv_image;
  logic               inv_hit;

  assign victim = (FILL_MODE == 1) ? lfsr_q[IDX_W-1:0] : fill_ptr_q;

  // A TLB refill exception forces the entry valid regardless of TLBIDX.NE
  always_comb begin
    wr_image        = csr_entry;
    wr_image[E_BIT] = csr_refill | ~csr_ne;
  end

  always_comb begin
    inv_image        = r_entry;
    inv_image[E_BIT] = 1'b0;
  end

  tlb_inv_match u_match (
    .entry_i  (r_entry),
    .inv_op_i (inv_op_q),
    .asid_i   (inv_asid_q),
    .vppn_i   (inv_vppn_q),
    .match_o  (inv_hit)
  );

  assign req_ready  = (state_q == ST_IDLE);
  assign done_valid = (state_q == ST_DONE);
  assign done_err   = done_valid & done_err_q;
  assign rd_entry   = rd_entry_q;
  assign rd_hit     = rd_entry_q[E_BIT];

  always_comb begin
    state_d    = state_q;
    done_err_d = done_err_q;
    rd_entry_d = rd_entry_q;
    fill_ptr_d = fill_ptr_q;
    lfsr_d     = lfsr_q;
    scan_ptr_d = scan_ptr_q;
    inv_op_d   = inv_op_q;
    inv_asid_d = inv_asid_q;
    inv_vppn_d = inv_vppn_q;
    r_index    = csr_idx;
    w_we       = 1'b0;
    w_index    = csr_idx;
    w_entry    = wr_image;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d    = ST_DONE;
          done_err_d = 1'b0;
          case (req_op)
            OP_RD: rd_entry_d = r_entry;
            OP_WR: w_we = 1'b1;
            OP_FILL: begin
              w_we       = 1'b1;
              w_index    = victim;
              fill_ptr_d = fill_ptr_q + 1'b1;
              lfsr_d     = lfsr_next(lfsr_q);
            end
            OP_INV: begin
              inv_op_d   = req_inv_op;
              inv_asid_d = req_inv_asid;
              inv_vppn_d = req_inv_vppn;
              scan_ptr_d = '0;
              if (req_inv_op > INV_OP_MAX) begin
                done_err_d = 1'b1;
              end else begin
                state_d = ST_SCAN;
              end
            end
            default: ;
          endcase
        end
      end

      // One entry per cycle: read, and write back with E cleared on a hit
      ST_SCAN: begin
        r_index    = scan_ptr_q;
        w_index    = scan_ptr_q;
        w_entry    = inv_image;
        w_we       = r_entry[E_BIT] & inv_hit;
        scan_ptr_d = scan_ptr_q + 1'b1;
        if (scan_ptr_q == LAST_IDX) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      done_err_q <= 1'b0;
      rd_entry_q <= '0;
      fill_ptr_q <= '0;
      lfsr_q     <= LFSR_SEED;
      scan_ptr_q <= '0;
    end else begin
      state_q    <= state_d;
      done_err_q <= done_err_d;
      rd_entry_q <= rd_entry_d;
      fill_ptr_q <= fill_ptr_d;
      lfsr_q     <= lfsr_d;
      scan_ptr_q <= scan_ptr_d;
    end
  end

  // Operand latches only matter while SCAN is running
  always_ff @(posedge clk) begin
    inv_op_q   <= inv_op_d;
    inv_asid_q <= inv_asid_d;
    inv_vppn_q <= inv_vppn_d;
  end

endmodule

// File: tb/tb_tlb_maint_unit.sv
module tb_tlb_maint_unit;

  localparam int N  = 16;
  localparam int IW = 4;

  typedef struct packed {
    logic        e;
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic [9:0]  asid;
    logic        g;
    logic [51:0] pg;
  } ent_t;

  typedef struct {
    bit   ready;
    bit   we;
    int   idx;
    ent_t went;
    bit   dv;
    bit   derr;
    ent_t rd;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_valid1;
  logic        req_ready, req_ready1;
  logic [2:0]  req_op;
  logic [4:0]  req_inv_op;
  logic [9:0]  req_inv_asid;
  logic [18:0] req_inv_vppn;
  logic [IW-1:0] csr_idx;
  logic        csr_ne, csr_refill;
  logic [88:0] csr_entry;
  logic [IW-1:0] r_index, r_index1;
  logic [88:0] r_entry;
  logic [88:0] r_entry1;
  logic        w_we, w_we1;
  logic [IW-1:0] w_index, w_index1;
  logic [88:0] w_entry, w_entry1;
  logic        done_valid, done_valid1;
  logic        done_err, done_err1;
  logic [88:0] rd_entry, rd_entry1;
  logic        rd_hit, rd_hit1;

  always #5 clk = ~clk;

  tlb_maint_unit #(.TLBNUM(N), .FILL_MODE(0)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_inv_op(req_inv_op), .req_inv_asid(req_inv_asid),
    .req_inv_vppn(req_inv_vppn), .csr_idx(csr_idx), .csr_ne(csr_ne),
    .csr_refill(csr_refill), .csr_entry(csr_entry), .r_index(r_index),
    .r_entry(r_entry), .w_we(w_we), .w_index(w_index), .w_entry(w_entry),
    .done_valid(done_valid), .done_err(done_err), .rd_entry(rd_entry),
    .rd_hit(rd_hit)
  );

  assign r_entry1 = '0;

  tlb_maint_unit #(.TLBNUM(N), .FILL_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_op(req_op), .req_inv_op(req_inv_op), .req_inv_asid(req_inv_asid),
    .req_inv_vppn(req_inv_vppn), .csr_idx(csr_idx), .csr_ne(csr_ne),
    .csr_refill(csr_refill), .csr_entry(csr_entry), .r_index(r_index1),
    .r_entry(r_entry1), .w_we(w_we1), .w_index(w_index1), .w_entry(w_entry1),
    .done_valid(done_valid1), .done_err(done_err1), .rd_entry(rd_entry1),
    .rd_hit(rd_hit1)
  );

  // TLB array seen by the main DUT
  logic [88:0] tlb_mem [N];
  assign r_entry = tlb_mem[r_index];
  always @(posedge clk) if (w_we) tlb_mem[w_index] <= w_entry;

  // Reference model state
  ent_t  mmem [N];
  ent_t  m_rd;
  int    m_fill;
  rec_t  q[$];
  int    checks = 0;
  int    errors = 0;
  bit    chk_en = 0;
  int    obs_wcnt, obs_widx;

  task automatic chk(input string nm, input logic [88:0] act, input logic [88:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic rec_t idle_rec();
    rec_t r;
    r.ready = 1; r.we = 0; r.idx = 0; r.went = '0;
    r.dv = 0; r.derr = 0; r.rd = m_rd;
    return r;
  endfunction

  function automatic bit vmatch(ent_t e, logic [18:0] v);
    if (e.ps == 6'd21) return e.vppn[18:9] == v[18:9];
    return e.vppn == v;
  endfunction

  function automatic bit inv_match(int op, ent_t e, logic [9:0] a, logic [18:0] v);
    case (op)
      0, 1:    return 1'b1;
      2:       return e.g;
      3:       return !e.g;
      4:       return !e.g && e.asid == a;
      5:       return !e.g && e.asid == a && vmatch(e, v);
      6:       return (e.g || e.asid == a) && vmatch(e, v);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] lfsr_step(logic [15:0] x);
    return {x[0] ^ x[2] ^ x[3] ^ x[5], x[15:1]};
  endfunction

  function automatic ent_t mk(logic e, logic [18:0] vppn, logic [5:0] ps,
                              logic [9:0] asid, logic g);
    ent_t t;
    t.e = e; t.vppn = vppn; t.ps = ps; t.asid = asid; t.g = g;
    t.pg = 52'({$urandom(), $urandom()});
    return t;
  endfunction

  // Per-cycle comparison against the expected-cycle queue
  always @(negedge clk) begin : cmp
    rec_t r;
    if (chk_en && !reset) begin
      if (q.size() > 0) r = q.pop_front();
      else r = idle_rec();
      chk("req_ready", req_ready, r.ready);
      chk("w_we", w_we, r.we);
      if (r.we) begin
        chk("w_index", w_index, r.idx);
        chk("w_entry", w_entry, r.went);
      end
      chk("done_valid", done_valid, r.dv);
      chk("done_err", done_err, r.derr);
      chk("rd_entry", rd_entry, r.rd);
      chk("rd_hit", rd_hit, r.rd.e);
      if (w_we === 1'b1) begin
        obs_wcnt++;
        obs_widx = int'(w_index);
      end
    end
  end

  // Issue the op currently on the request inputs; model builds the expected
  // cycle sequence from accept through done.
  task automatic issue(output int lat, output bit derr_seen);
    rec_t r;
    ent_t e;
    int   v;
    obs_wcnt = 0;
    obs_widx = -1;
    @(posedge clk); #1;
    req_valid = 1;
    r = idle_rec();
    case (req_op)
      3'd1: begin
        q.push_back(r);
        r.ready = 0; r.dv = 1; r.rd = mmem[csr_idx]; m_rd = r.rd;
        q.push_back(r);
      end
      3'd2, 3'd3: begin
        e = csr_entry;
        e.e = csr_refill | ~csr_ne;
        if (req_op == 3'd3) begin
          v = m_fill; m_fill = (m_fill + 1) % N;
        end else v = int'(csr_idx);
        r.we = 1; r.idx = v; r.went = e;
        q.push_back(r);
        mmem[v] = e;
        r.we = 0; r.ready = 0; r.dv = 1;
        q.push_back(r);
      end
      3'd4: begin
        q.push_back(r);
        r.ready = 0;
        if (req_inv_op > 5'd6) begin
          r.dv = 1; r.derr = 1;
          q.push_back(r);
        end else begin
          for (int i = 0; i < N; i++) begin
            r.we = 0;
            e = mmem[i];
            if (e.e && inv_match(int'(req_inv_op), e, req_inv_asid, req_inv_vppn)) begin
              e.e = 0; r.we = 1; r.idx = i; r.went = e; mmem[i] = e;
            end
            q.push_back(r);
          end
          r.we = 0; r.dv = 1;
          q.push_back(r);
        end
      end
      default: begin
        q.push_back(r);
        r.ready = 0; r.dv = 1;
        q.push_back(r);
      end
    endcase
    @(negedge clk);
    @(posedge clk); #1;
    req_valid = 0;
    lat = -1;
    derr_seen = 0;
    for (int k = 1; k < 64; k++) begin
      @(negedge clk);
      if (done_valid === 1'b1) begin
        lat = k;
        derr_seen = done_err;
        break;
      end
    end
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done_valid expected one within 63 cycles");
    end
  endtask

  task automatic do_wr(input int idx, input ent_t e, input bit ne, input bit refl, output int lat);
    bit d;
    req_op = 3'd2; csr_idx = IW'(idx); csr_entry = e; csr_ne = ne; csr_refill = refl;
    issue(lat, d);
  endtask

  task automatic do_inv(input int op, input logic [9:0] a, input logic [18:0] v,
                        output int lat, output bit d);
    req_op = 3'd4; req_inv_op = 5'(op); req_inv_asid = a; req_inv_vppn = v;
    issue(lat, d);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin : main
    int   lat;
    bit   d;
    ent_t e7, e9, e;
    logic [15:0] l;
    logic [9:0]  apool [3];
    logic [18:0] vpool [3];
    rec_t r;

    apool[0] = 10'h12; apool[1] = 10'h34; apool[2] = 10'h55;
    vpool[0] = 19'h04000; vpool[1] = 19'h2A000; vpool[2] = 19'h13579;
    reset = 1; req_valid = 0; req_valid1 = 0; req_op = 0; req_inv_op = 0;
    req_inv_asid = 0; req_inv_vppn = 0; csr_idx = 0; csr_ne = 0;
    csr_refill = 0; csr_entry = '0;
    for (int i = 0; i < N; i++) begin tlb_mem[i] = '0; mmem[i] = '0; end
    m_rd = '0; m_fill = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    chk_en = 1;
    @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_done", done_valid, 0);
    chk("rst_rd_entry", rd_entry, 0);
    chk("rst_rd_hit", rd_hit, 0);
    chk("rst_ready1", req_ready1, 1);

    // WR idx 5, NE=0 -> E=1, done one cycle after accept
    do_wr(5, mk(0, 19'h00111, 6'd12, 10'h1, 0), 0, 0, lat);
    chk("wr5_lat", lat, 1);
    chk("wr5_cnt", obs_wcnt, 1);
    chk("wr5_idx", obs_widx, 5);
    chk("wr5_E", tlb_mem[5][88], 1);
    do_wr(6, mk(0, 19'h00222, 6'd12, 10'h1, 0), 1, 1, lat);
    chk("wr_refill_E", tlb_mem[6][88], 1);
    do_wr(6, mk(1, 19'h00222, 6'd12, 10'h1, 0), 1, 0, lat);
    chk("wr_ne_E", tlb_mem[6][88], 0);

    // 17 round-robin FILLs
    csr_ne = 0; csr_refill = 0;
    for (int i = 0; i < 17; i++) begin
      req_op = 3'd3; csr_entry = mk(0, 19'h7FFFF, 6'd12, 10'h3FF, 1);
      issue(lat, d);
      chk("fill_rr_idx", obs_widx, i % 16);
    end

    // LFSR-mode victims on the second instance
    l = 16'hACE1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      req_op = 3'd3; req_valid1 = 1;
      @(negedge clk);
      chk("lfsr_we", w_we1, 1);
      chk("lfsr_idx", w_index1, l[3:0]);
      if (i == 0) chk("lfsr_first", w_index1, 4'd1);
      l = lfsr_step(l);
      @(posedge clk); #1;
      req_valid1 = 0;
      @(negedge clk);
      chk("lfsr_done", done_valid1, 1);
    end

    // INV op 5: only entry 7 qualifies
    do_wr(3, mk(0, 19'h04000, 6'd12, 10'h12, 1), 0, 0, lat);
    e7 = mk(0, 19'h04000, 6'd12, 10'h12, 0);
    do_wr(7, e7, 0, 0, lat);
    do_inv(5, 10'h12, 19'h04000, lat, d);
    chk("inv5_lat", lat, 17);
    chk("inv5_cnt", obs_wcnt, 1);
    chk("inv5_idx", obs_widx, 7);

    // INV op 6 with PS=21 entry differing only in vppn[8:0]
    e9 = mk(0, 19'h2A000 ^ 19'h001AB, 6'd21, 10'h55, 0);
    do_wr(9, e9, 0, 0, lat);
    do_inv(6, 10'h55, 19'h2A000, lat, d);
    chk("inv6_cnt", obs_wcnt, 1);
    chk("inv6_idx", obs_widx, 9);

    // INV op 7 is illegal
    do_inv(7, 10'h55, 19'h2A000, lat, d);
    chk("inv7_err", d, 1);
    chk("inv7_cnt", obs_wcnt, 0);
    chk("inv7_lat", lat, 1);

    // RD index 7 after invalidation
    req_op = 3'd1; csr_idx = 4'd7;
    issue(lat, d);
    chk("rd7_lat", lat, 1);
    chk("rd7_hit", rd_hit, 0);
    chk("rd7_entry", rd_entry, {1'b0, e7[87:0]});

    // Randomized mix
    for (int n = 0; n < 150; n++) begin
      int sel;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      e = mk(1'($urandom), vpool[$urandom_range(0, 2)] ^ 19'($urandom_range(0, 1) * $urandom_range(0, 511)),
             ($urandom_range(0, 1) != 0) ? 6'd21 : 6'd12, apool[$urandom_range(0, 2)], 1'($urandom));
      sel = $urandom_range(0, 9);
      csr_idx = IW'($urandom_range(0, N - 1));
      csr_ne = 1'($urandom); csr_refill = 1'($urandom); csr_entry = e;
      req_inv_op = 5'($urandom_range(0, 9));
      req_inv_asid = apool[$urandom_range(0, 2)];
      req_inv_vppn = vpool[$urandom_range(0, 2)] ^ 19'($urandom_range(0, 3));
      if (sel < 3) req_op = 3'd2;
      else if (sel < 5) req_op = 3'd3;
      else if (sel < 7) req_op = 3'd1;
      else if (sel < 9) req_op = 3'd4;
      else req_op = ($urandom_range(0, 1) != 0) ? 3'd0 : 3'(5 + $urandom_range(0, 2));
      issue(lat, d);
    end

    // Reset in the middle of a scan (at scan_ptr == 4)
    for (int i = 0; i < 4; i++) do_wr(i, mk(0, 19'h01234, 6'd12, 10'h77, 0), 0, 0, lat);
    do_wr(4, mk(1, 19'h01234, 6'd12, 10'h77, 0), 1, 0, lat);
    req_op = 3'd4; req_inv_op = 5'd4; req_inv_asid = 10'h77; req_inv_vppn = 19'h0;
    @(posedge clk); #1;
    req_valid = 1;
    r = idle_rec();
    q.push_back(r);
    r.ready = 0;
    for (int i = 0; i < 4; i++) begin
      r.we = 0;
      e = mmem[i];
      if (e.e && inv_match(4, e, 10'h77, 19'h0)) begin
        e.e = 0; r.we = 1; r.idx = i; r.went = e; mmem[i] = e;
      end
      q.push_back(r);
    end
    @(posedge clk); #1;
    req_valid = 0;
    repeat (4) begin @(posedge clk); #1; end
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    m_rd = '0; m_fill = 0;
    q.delete();
    @(negedge clk);
    chk("abort_ready", req_ready, 1);
    repeat (20) @(negedge clk);
    for (int i = 0; i < N; i++) chk("mem_final", tlb_mem[i], mmem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tlb_maint_unit.md
Name: tlb_maint_unit

Overview:
Parametrised TLB maintenance engine that sits beside the writeback stage. It executes TLBRD, TLBWR, TLBFILL and INVTLB against the TLB array through one read port and one write port. The WB stage issues one op per valid/ready handshake and assembles the CSR-side entry image. This block owns the TLBFILL replacement policy and multi-cycle INVTLB scanning, so the TLB array can grow beyond a single-cycle invalidate.

Parameters:
TLBNUM, 16, number of TLB entries; power of two, 2..64.
FILL_MODE, 0, TLBFILL victim policy: 0 = round-robin, 1 = 16-bit LFSR.
IDX_W, $clog2(TLBNUM), local; index width.

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-high
req_valid  in  1  op request from WB, valid only for committed, non-excepting instructions
req_ready  out  1  unit idle; accepts an op this cycle
req_op  in  3  1=RD, 2=WR, 3=FILL, 4=INV; other codes are no-ops
req_inv_op  in  5  INVTLB op field
req_inv_asid  in  10  INVTLB rj[9:0]
req_inv_vppn  in  19  INVTLB rk[31:13]
csr_idx  in  IDX_W  TLBIDX.index
csr_ne  in  1  TLBIDX.NE
csr_refill  in  1  ESTAT.Ecode==TLBR (forces E=1 on WR/FILL)
csr_entry  in  ENTRY_W  packed entry from TLBIDX/TLBEHI/TLBELO0/TLBELO1/ASID; G = ELO0.G & ELO1.G
r_index  out  IDX_W  TLB read port index
r_entry  in  ENTRY_W  TLB read data, combinational
w_we  out  1  TLB write enable
w_index  out  IDX_W  TLB write index
w_entry  out  ENTRY_W  TLB write data
done_valid  out  1  one-cycle pulse on op completion
done_err  out  1  with done_valid: INV had an illegal op (>6)
rd_entry  out  ENTRY_W  TLBRD result, held until the next RD completes
rd_hit  out  1  rd_entry.E

Behaviour:
- FSM states: IDLE, SCAN, DONE.
- req_ready = (state==IDLE). Accept = req_valid & req_ready.
- Reset values: state IDLE, done_valid 0, done_err 0, rd_entry 0, rd_hit 0, fill_ptr 0, lfsr 16'hACE1, scan_ptr 0.
- w_we is 0 whenever the unit is not accepting WR/FILL and not in a SCAN write.
- RD:
  - Accept cycle: r_index=csr_idx.
  - Next edge: rd_entry<=r_entry; state DONE.
  - done_valid is high for exactly one cycle (the DONE cycle), then the FSM returns to IDLE.
  - Latency: done 1 cycle after accept.
- WR:
  - Accept cycle, combinational: w_we=1, w_index=csr_idx, w_entry=csr_entry with E = csr_refill | ~csr_ne.
  - Then DONE.
- FILL:
  - Same as WR, but w_index = victim.
  - Round-robin mode: victim = fill_ptr; fill_ptr wraps from TLBNUM-1 to 0.
  - LFSR mode: victim = lfsr[IDX_W-1:0].
  - The victim pointer advances only on an accepted FILL. Polynomial: x^16+x^14+x^13+x^11+1.
- INV:
  - On accept, latch inv_op, asid and vppn; set scan_ptr=0.
  - If inv_op>6: go to DONE with done_err=1 and perform no writes.
  - Otherwise go to SCAN.
  - SCAN, each cycle:
    - r_index=scan_ptr.
    - If r_entry.E and the entry matches: w_we=1, w_index=scan_ptr, w_entry=r_entry with E=0.
    - Increment scan_ptr.
    - After entry TLBNUM-1, go to DONE.
  - INV latency: TLBNUM+1 cycles from accept to done_valid.
- Match rules:
  - op 0,1: all entries.
  - op 2: G=1.
  - op 3: G=0.
  - op 4: G=0 & asid==ASID.
  - op 5: G=0 & asid==ASID & vppn match.
  - op 6: (G=1 | asid==ASID) & vppn match.
- vppn match: if PS==21, compare vppn[18:9] only; otherwise compare all 19 bits.
- Ops outside 1..4 are accepted and complete via DONE with no side effects.
- A reset in the middle of SCAN aborts immediately. Entries already invalidated stay invalid. No done pulse is issued.

Decomposition:
- Package tlb_pkg:
  - op codes.
  - ENTRY_W=89.
  - Field offsets {E, VPPN19, PS6, ASID10, G, PPN0 20, PLV0, MAT0, D0, V0, PPN1 20, PLV1, MAT1, D1, V1}.
  - INVTLB op encodings.
  - LFSR seed and taps.
- Sub-module tlb_inv_match: combinational match of one entry against {inv_op, asid, vppn}, reused by the SRCH path later.

Test Plan:
- TLBNUM=16: WR with csr_idx=5, csr_ne=0, csr_refill=0 -> w_we for one cycle, w_index=5, E=1; done_valid 1 cycle later.
- WR with csr_ne=1, csr_refill=1 -> E=1. WR with csr_ne=1, csr_refill=0 -> E=0.
- 17 FILLs in round-robin mode -> w_index 0,1,...,15,0. FILL_MODE=1 -> first victim = 16'hACE1[3:0]=1, then LFSR successors.
- Write entries 3 (G=1) and 7 (G=0, ASID=0x12, VPPN=0x4000), then INV op 5 with asid=0x12, vppn=0x4000 -> only entry 7 written with E=0; done_valid exactly 17 cycles after accept; req_ready low in between.
- INV op 6 on a PS=21 entry differing only in vppn[8:0] -> invalidated. INV op 7 -> done_err=1, no w_we.
- RD at index 7 after invalidation -> rd_hit=0 and rd_entry fields equal the stored entry. Reset asserted at scan_ptr=4 -> IDLE, req_ready=1, no done_valid.
